// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-client round-robin arbiter and command sequencer in front of a
// single-port sram_top macro. Each client hands over read or write commands
// on a valid/ready handshake. The arbiter serialises them onto the SRAM pins
// and sends read data back to the client that issued the read, once the
// fixed SRAM read latency has elapsed.
//
// Parameters:
//   WIDTH       data width (matches sram_top)
//   DEPTH       number of SRAM words (matches sram_top)
//   ADDR_WIDTH  word address width
//   RD_LAT      sram_top read latency in cycles, legal range 1..4
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   reqN_valid/we/addr/wdata  client N command (we = 1 means write)
//   reqN_ready                client N command accepted when valid && ready
//   rspN_valid                one-cycle read-data strobe to client N
//   rspN_rdata                client N read data, held until its next response
//   sram_wr_req, sram_re_req  registered SRAM strobes, high only in ISSUE
//   sram_addr, sram_din       registered SRAM address / write data
//   sram_dout                 SRAM read data
//   busy                      high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [WIDTH-1:0]      rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [WIDTH-1:0]      rsp1_rdata,
  output logic                  sram_wr_req,
  output logic                  sram_re_req,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_din,
  input  logic [WIDTH-1:0]      sram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Three bits are enough for the largest legal latency (4).
  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  RD_LAT_C = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  state_t                  state_r;
  state_t                  state_s;
  logic                    last_grant_r;
  logic                    grant_s;
  logic                    hs_s;
  logic                    hs_we_s;
  logic [ADDR_WIDTH-1:0]   hs_addr_s;
  logic [WIDTH-1:0]        hs_wdata_s;
  logic                    id_r;
  logic                    we_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    wait_done_s;

  // Round-robin pick: under contention the client not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Output decode: ready goes only to the granted client, only in IDLE and never in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      req0_ready = req0_valid && !grant_s;
      req1_ready = req1_valid && grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    busy = (state_r != IDLE);
  end

  // Handshake detection and selection of the granted client's command fields.
  always_comb begin
    hs_s       = req0_ready || req1_ready;
    hs_we_s    = 1'b0;
    hs_addr_s  = {ADDR_WIDTH{1'b0}};
    hs_wdata_s = {WIDTH{1'b0}};
    if (grant_s) begin
      hs_we_s    = req1_we;
      hs_addr_s  = req1_addr;
      hs_wdata_s = req1_wdata;
    end else begin
      hs_we_s    = req0_we;
      hs_addr_s  = req0_addr;
      hs_wdata_s = req0_wdata;
    end
  end

  // The last WAIT cycle is the one where the counter is down to one.
  always_comb begin
    wait_done_s = 1'b0;
    if ((state_r == WAIT) && (cnt_r == CNT_ONE)) begin
      wait_done_s = 1'b1;
    end else begin
      wait_done_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (wait_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Command capture: the strobes are registered at the handshake edge so they
  // are high for exactly the ISSUE cycle; address/data hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      we_r         <= 1'b0;
      sram_wr_req  <= 1'b0;
      sram_re_req  <= 1'b0;
      sram_addr    <= {ADDR_WIDTH{1'b0}};
      sram_din     <= {WIDTH{1'b0}};
    end else begin
      sram_wr_req <= hs_s && hs_we_s;
      sram_re_req <= hs_s && !hs_we_s;
      if (hs_s) begin
        last_grant_r <= grant_s;
        id_r         <= grant_s;
        we_r         <= hs_we_s;
        sram_addr    <= hs_addr_s;
        sram_din     <= hs_wdata_s;
      end
    end
  end

  // Read-latency counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (state_r == ISSUE) begin
      cnt_r <= RD_LAT_C;
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Read return: capture sram_dout on the final WAIT edge for the stored client.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= {WIDTH{1'b0}};
      rsp1_rdata <= {WIDTH{1'b0}};
    end else begin
      rsp0_valid <= wait_done_s && !id_r;
      rsp1_valid <= wait_done_s && id_r;
      if (wait_done_s && !id_r) begin
        rsp0_rdata <= sram_dout;
      end
      if (wait_done_s && id_r) begin
        rsp1_rdata <= sram_dout;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int WIDTH = 4;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int LAT   = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- main DUT (RD_LAT = 1) ----------------
  logic             req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0]    req0_addr, req1_addr;
  logic [WIDTH-1:0] req0_wdata, req1_wdata;
  logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_rdata, rsp1_rdata;
  logic             sram_wr_req, sram_re_req, busy;
  logic [AW-1:0]    sram_addr;
  logic [WIDTH-1:0] sram_din, sram_dout;

  sram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_wr_req(sram_wr_req), .sram_re_req(sram_re_req), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout), .busy(busy)
  );

  // SRAM behavioural model, latency 1
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] dout_a = 4'd0;
  always @(posedge clk) begin
    if (sram_wr_req) mem_a[sram_addr] <= sram_din;
    if (sram_re_req) dout_a <= mem_a[sram_addr];
  end
  assign sram_dout = dout_a;

  // ---------------- second DUT (RD_LAT = 3) ----------------
  logic             b_req0_valid, b_req0_we, b_req1_valid, b_req1_we;
  logic [AW-1:0]    b_req0_addr, b_req1_addr;
  logic [WIDTH-1:0] b_req0_wdata, b_req1_wdata;
  logic             b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic [WIDTH-1:0] b_rsp0_rdata, b_rsp1_rdata;
  logic             b_wr_req, b_re_req, b_busy;
  logic [AW-1:0]    b_addr;
  logic [WIDTH-1:0] b_din, b_dout;

  sram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata), .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .sram_wr_req(b_wr_req), .sram_re_req(b_re_req), .sram_addr(b_addr), .sram_din(b_din),
    .sram_dout(b_dout), .busy(b_busy)
  );

  // SRAM behavioural model, latency 3
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] b_p0 = 4'd0, b_p1 = 4'd0, b_p2 = 4'd0;
  always @(posedge clk) begin
    if (b_wr_req) mem_b[b_addr] <= b_din;
    if (b_re_req) b_p0 <= mem_b[b_addr];
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_dout = b_p2;

  // ---------------- checking ----------------
  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [31:0]      cyc;
  } strobe_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [31:0]      cyc;
  } rd_t;

  strobe_t          strobe_q[$];
  rd_t              rd0_q[$];
  rd_t              rd1_q[$];
  int               grant_log[$];
  logic [31:0]      hs_cyc_log[$];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               rsp0_cnt = 0;
  int               rsp1_cnt = 0;

  // Record an accepted command: expected strobe, expected read data, grant order.
  task automatic record(input int c, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    strobe_t s;
    rd_t     r;
    s.we = we; s.addr = a; s.data = d; s.cyc = cyc + 32'd1;
    strobe_q.push_back(s);
    if (we) begin
      ref_mem[a] = d;
    end else begin
      r.data = ref_mem[a];
      r.cyc  = cyc + 32'(2 + LAT);
      if (c == 0) rd0_q.push_back(r);
      else        rd1_q.push_back(r);
    end
    grant_log.push_back(c);
    hs_cyc_log.push_back(cyc);
  endtask

  // Monitor for the main DUT, sampling on the falling edge.
  initial begin
    strobe_t s;
    rd_t     r;
    forever begin
      @(negedge clk);
      if (rst) begin
        strobe_q.delete();
        rd0_q.delete();
        rd1_q.delete();
      end else begin
        if (sram_wr_req || sram_re_req) begin
          chk("strobe_excl", 32'(sram_wr_req & sram_re_req), 32'd0);
          if (strobe_q.size() == 0) begin
            chk("strobe_unexpected", 32'd1, 32'd0);
          end else begin
            s = strobe_q.pop_front();
            chk("strobe_we", 32'(sram_wr_req), 32'(s.we));
            chk("strobe_addr", 32'(sram_addr), 32'(s.addr));
            chk("strobe_din", 32'(sram_din), 32'(s.data));
            chk("strobe_cycle", cyc, s.cyc);
          end
        end
        if (rsp0_valid) begin
          rsp0_cnt++;
          chk("rsp_excl", 32'(rsp1_valid), 32'd0);
          if (rd0_q.size() == 0) begin
            chk("rsp0_unexpected", 32'd1, 32'd0);
          end else begin
            r = rd0_q.pop_front();
            chk("rsp0_data", 32'(rsp0_rdata), 32'(r.data));
            chk("rsp0_cycle", cyc, r.cyc);
          end
        end
        if (rsp1_valid) begin
          rsp1_cnt++;
          if (rd1_q.size() == 0) begin
            chk("rsp1_unexpected", 32'd1, 32'd0);
          end else begin
            r = rd1_q.pop_front();
            chk("rsp1_data", 32'(rsp1_rdata), 32'(r.data));
            chk("rsp1_cycle", cyc, r.cyc);
          end
        end
        if (req0_ready && req1_ready) chk("ready_excl", 32'd1, 32'd0);
        if (req0_valid && req0_ready) record(0, req0_we, req0_addr, req0_wdata);
        if (req1_valid && req1_ready) record(1, req1_we, req1_addr, req1_wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int c, input logic v, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (c == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic op(input int c, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    int   n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    drive(c, 1'b1, we, a, d);
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (c == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!rdy) chk("op_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    drive(c, 1'b0, 1'b0, 5'd0, 4'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((strobe_q.size() + rd0_q.size() + rd1_q.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_ready0"}, 32'(req0_ready), 32'd0);
    chk({pfx, "_ready1"}, 32'(req1_ready), 32'd0);
    chk({pfx, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
    chk({pfx, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
    chk({pfx, "_rsp0_rdata"}, 32'(rsp0_rdata), 32'd0);
    chk({pfx, "_rsp1_rdata"}, 32'(rsp1_rdata), 32'd0);
    chk({pfx, "_wr_req"}, 32'(sram_wr_req), 32'd0);
    chk({pfx, "_re_req"}, 32'(sram_re_req), 32'd0);
    chk({pfx, "_addr"}, 32'(sram_addr), 32'd0);
    chk({pfx, "_din"}, 32'(sram_din), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic b_op(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, output logic [31:0] hs);
    int n;
    n = 0;
    b_req0_valid = 1'b1; b_req0_we = we; b_req0_addr = a; b_req0_wdata = d;
    hs = 32'd0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_req0_ready && n < 200);
    if (!b_req0_ready) chk("b_op_timeout", 32'd1, 32'd0);
    hs = cyc;
    @(posedge clk); #1;
    b_req0_valid = 1'b0; b_req0_we = 1'b0; b_req0_addr = 5'd0; b_req0_wdata = 4'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int          base;
    int          r0;
    int          r1;
    int          nb;
    int          rk;
    logic [31:0] hs;
    logic [WIDTH-1:0] rdat;

    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 4'd0; mem_b[i] = 4'd0; ref_mem[i] = 4'd0;
    end
    drive(0, 1'b0, 1'b0, 5'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 4'd0);
    b_req0_valid = 1'b0; b_req0_we = 1'b0; b_req0_addr = 5'd0; b_req0_wdata = 4'd0;
    b_req1_valid = 1'b0; b_req1_we = 1'b0; b_req1_addr = 5'd0; b_req1_wdata = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");

    // Contention from reset release: grants 0,1,0,1, one write per 2 cycles
    drive(0, 1'b1, 1'b1, 5'd0, 4'h1);
    drive(1, 1'b1, 1'b1, 5'd1, 4'h2);
    @(negedge clk);
    chk("ready0_in_rst", 32'(req0_ready), 32'd0);
    chk("ready1_in_rst", 32'(req1_ready), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    base = grant_log.size();
    fork
      begin op(0, 1'b1, 5'd0, 4'h1); op(0, 1'b1, 5'd0, 4'h1); end
      begin op(1, 1'b1, 5'd1, 4'h2); op(1, 1'b1, 5'd1, 4'h2); end
    join
    drain();
    chk("cont_grant_cnt", 32'(grant_log.size() - base), 32'd4);
    if (grant_log.size() >= base + 4) begin
      chk("cont_grant0", 32'(grant_log[base]),   32'd0);
      chk("cont_grant1", 32'(grant_log[base+1]), 32'd1);
      chk("cont_grant2", 32'(grant_log[base+2]), 32'd0);
      chk("cont_grant3", 32'(grant_log[base+3]), 32'd1);
      for (int i = 1; i < 4; i++)
        chk("cont_spacing", hs_cyc_log[base+i] - hs_cyc_log[base+i-1], 32'd2);
    end

    // Single write then read, client 0
    op(0, 1'b1, 5'd5, 4'hA);
    op(0, 1'b0, 5'd5, 4'h0);
    drain();
    chk("wr_rd_rsp0_cnt", 32'(rsp0_cnt), 32'd1);
    chk("wr_rd_rsp0_data", 32'(rsp0_rdata), 32'hA);
    chk("wr_rd_rsp1_cnt", 32'(rsp1_cnt), 32'd0);
    chk("wr_rd_rsp1_rdata", 32'(rsp1_rdata), 32'd0);

    // Interleaved: last_grant = 0, so client 1's write beats client 0's read
    base = grant_log.size();
    fork
      op(0, 1'b0, 5'd7, 4'h0);
      op(1, 1'b1, 5'd7, 4'h3);
    join
    drain();
    chk("intl_first", 32'(grant_log[base]), 32'd1);
    chk("intl_second", 32'(grant_log[base+1]), 32'd0);
    chk("intl_rdata", 32'(rsp0_rdata), 32'h3);

    // Fill and check, client 1
    r0 = rsp0_cnt;
    r1 = rsp1_cnt;
    for (int a = 0; a < DEPTH; a++) op(1, 1'b1, AW'(a), 4'b1010);
    for (int a = 0; a < DEPTH; a++) op(1, 1'b0, AW'(a), 4'h0);
    drain();
    chk("fill_rsp1_cnt", 32'(rsp1_cnt - r1), 32'd32);
    chk("fill_rsp0_cnt", 32'(rsp0_cnt - r0), 32'd0);
    chk("fill_last_data", 32'(rsp1_rdata), 32'hA);

    // Reset during WAIT
    r0 = rsp0_cnt;
    op(0, 1'b0, 5'd5, 4'hF);
    @(posedge clk); #1;
    chk("mid_in_wait_busy", 32'(busy), 32'd1);
    chk("mid_in_wait_re", 32'(sram_re_req), 32'd0);
    rst = 1'b1;
    #1;
    check_reset("mid");
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    base = grant_log.size();
    fork
      op(0, 1'b1, 5'd10, 4'h5);
      op(1, 1'b1, 5'd11, 4'h6);
    join
    chk("post_rst_first", 32'(grant_log[base]), 32'd0);
    op(0, 1'b0, 5'd10, 4'h0);
    op(1, 1'b0, 5'd11, 4'h0);
    drain();
    chk("post_rst_rsp0_cnt", 32'(rsp0_cnt - r0), 32'd1);
    chk("post_rst_rdata0", 32'(rsp0_rdata), 32'h5);
    chk("post_rst_rdata1", 32'(rsp1_rdata), 32'h6);

    // RD_LAT = 3 build: write/read addr 5
    b_op(1'b1, 5'd5, 4'hA, hs);
    repeat (3) @(posedge clk);
    #1;
    b_op(1'b0, 5'd5, 4'h0, hs);
    nb = 0; rk = 0; rdat = 4'd0; r1 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b_busy) nb++;
      if (b_rsp0_valid) begin rk = k; rdat = b_rsp0_rdata; end
      if (b_rsp1_valid) r1++;
    end
    chk("lat3_rsp_cycle", 32'(rk), 32'd5);
    chk("lat3_busy_cycles", 32'(nb), 32'd4);
    chk("lat3_rdata", 32'(rdat), 32'hA);
    chk("lat3_rsp1", 32'(r1), 32'd0);

    chk("end_strobe_q", 32'(strobe_q.size()), 32'd0);
    chk("end_rd0_q", 32'(rd0_q.size()), 32'd0);
    chk("end_rd1_q", 32'(rd1_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
